// File: rtl/logic_op_pkg.sv
// Shared types and the bitwise evaluator for the shared 4-bit logic unit.
// Everything that decodes an opcode uses logic_op_eval, so the decode exists in one place.
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NOTA = 2'b11
    } logic_op_e;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } arb_state_e;

    // Every opcode is defined; b is ignored for NOT a.
    function automatic nibble_t logic_op_eval(input nibble_t a, input nibble_t b, input logic_op_e op);
        nibble_t r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request and result bundle between the command sources, the arbiter and the consumer.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface logic_op_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*4-1:0] req_a;
    logic [NREQ*4-1:0] req_b;
    logic [NREQ*2-1:0] req_sel;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_result;
    logic [IDW-1:0]    out_id;

    modport slave (
        input  req_valid, req_a, req_b, req_sel, out_ready,
        output req_ready, out_valid, out_result, out_id
    );

    modport master (
        output req_valid, req_a, req_b, req_sel, out_ready,
        input  req_ready, out_valid, out_result, out_id
    );
endinterface

// File: rtl/logic_op_unit.sv
// Combinational evaluator for one operand pair; instantiated once on the granted operands.
module logic_op_unit
    import logic_op_pkg::*;
(
    input  nibble_t   a,
    input  nibble_t   b,
    input  logic_op_e op,
    output nibble_t   result
);
    assign result = logic_op_eval(a, b, op);
endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin share of one logic unit among NREQ requesters, with a one-deep
// registered result stage that can drain and refill in the same cycle.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_op_arbiter_if.slave  bus,
    output logic [7:0]         busy_cnt
);

    if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
        $error("logic_op_arbiter: need 2<=NREQ<=8 and IDW == clog2(NREQ)");
    end

    arb_state_e     state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] id_reg;
    nibble_t        result_reg;
    logic [7:0]     busy_reg;

    nibble_t        a_arr   [NREQ];
    nibble_t        b_arr   [NREQ];
    logic_op_e      sel_arr [NREQ];

    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           can_accept;
    logic           handshake;
    nibble_t        unit_result;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (valid[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi]         = bus.req_a[4*gi +: 4];
        assign b_arr[gi]         = bus.req_b[4*gi +: 4];
        assign sel_arr[gi]       = logic_op_e'(bus.req_sel[2*gi +: 2]);
        // Gated by rst_n so ready is low for the whole time reset is held.
        assign bus.req_ready[gi] = rst_n & grant_found & can_accept & (grant_idx == IDW'(gi));
    end

    assign {grant_found, grant_idx} = rr_pick(bus.req_valid, rr_ptr_reg);
    assign can_accept = (state_reg == ST_IDLE) | bus.out_ready;
    assign handshake  = rst_n & grant_found & can_accept;

    logic_op_unit u_unit (
        .a      (a_arr[grant_idx]),
        .b      (b_arr[grant_idx]),
        .op     (sel_arr[grant_idx]),
        .result (unit_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (handshake) state_next = ST_FULL;
            ST_FULL: if (!handshake && bus.out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            result_reg <= '0;
            busy_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                result_reg <= unit_result;
                id_reg     <= grant_idx;
                rr_ptr_reg <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
                busy_reg   <= busy_reg + 8'd1;
            end
        end
    end

    assign bus.out_valid  = (state_reg == ST_FULL);
    assign bus.out_result = result_reg;
    assign bus.out_id     = id_reg;
    assign busy_cnt       = busy_reg;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench: stimulus pushes hand-computed results into a scoreboard queue and a
// negedge monitor pops and compares on every output transfer.
module tb_logic_op_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [3:0] res;
        logic [1:0] id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] busy_cnt;
    logic [7:0] exp_busy;
    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic_op_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    logic_op_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] res, input int id);
        exp_t e;
        e.res = res;
        e.id  = 2'(id);
        sb_q.push_back(e);
        exp_busy = exp_busy + 8'd1;
    endtask

    task automatic issue(input int g, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel, input logic [3:0] exp_res);
        bus.req_valid        = 4'(1 << g);
        bus.req_a[4*g +: 4]  = a;
        bus.req_b[4*g +: 4]  = b;
        bus.req_sel[2*g +: 2] = sel;
        #1;
        check($sformatf("req_ready_g%0d", g), 32'(bus.req_ready), 32'(1 << g));
        $display("issue: req %0d a=%h b=%h sel=%b expect %h", g, a, b, sel, exp_res);
        push_exp(exp_res, g);
        step();
        bus.req_valid = '0;
    endtask

    // Monitor: a transfer happens at the coming edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("out: id=%0d result=%h (expect id=%0d result=%h)",
                         bus.out_id, bus.out_result, e.id, e.res);
                check("out_result", 32'(bus.out_result), 32'(e.res));
                check("out_id", 32'(bus.out_id), 32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        exp_busy      = '0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_id", 32'(bus.out_id), 32'd0);
        check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        #10 rst_n = 1'b1;
        step();

        // Single requester: C & A = 8
        issue(0, 4'hC, 4'hA, 2'b00, 4'h8);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_busy_cnt", 32'(busy_cnt), 32'd1);

        // Opcode sweep on requester 2
        issue(2, 4'hC, 4'hA, 2'b01, 4'hE);
        issue(2, 4'hC, 4'hA, 2'b10, 4'h6);
        issue(2, 4'hC, 4'hA, 2'b11, 4'h3);

        // Move the pointer back to 0, then all four requesters held for 8 cycles
        issue(3, 4'hF, 4'h0, 2'b00, 4'h0);
        bus.req_a   = 16'h8421;
        bus.req_b   = 16'hFFFF;
        bus.req_sel = '0;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_req_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
            push_exp(4'(1 << (k % 4)), k % 4);
            step();
        end
        bus.req_valid = '0;
        check("rr_busy_cnt", 32'(busy_cnt), 32'(exp_busy));
        step();

        // Backpressure: hold a result for three cycles with everyone requesting
        bus.out_ready = 1'b0;
        issue(1, 4'h5, 4'h3, 2'b10, 4'h6);
        bus.req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_result", 32'(bus.out_result), 32'h6);
            check("bp_out_id", 32'(bus.out_id), 32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        issue(2, 4'h9, 4'h6, 2'b01, 4'hF);
        check("refill_out_id", 32'(bus.out_id), 32'd2);
        check("refill_out_valid", 32'(bus.out_valid), 32'd1);

        // Counter wrap: requester 0 alone until 256 operations have been granted
        bus.req_a[3:0]   = 4'hC;
        bus.req_b[3:0]   = 4'hA;
        bus.req_sel[1:0] = 2'b00;
        bus.req_valid    = 4'h1;
        while (exp_busy != 8'd0) begin
            push_exp(4'h8, 0);
            step();
        end
        bus.req_valid = '0;
        check("wrap_busy_cnt", 32'(busy_cnt), 32'd0);

        // Pointer to 3, then requesters 3 and 0 together: 3 first, then 0
        issue(2, 4'h1, 4'h2, 2'b01, 4'h3);
        bus.req_a[15:12]  = 4'hA;
        bus.req_b[15:12]  = 4'h5;
        bus.req_sel[7:6]  = 2'b10;
        bus.req_a[3:0]    = 4'h0;
        bus.req_sel[1:0]  = 2'b11;
        bus.req_valid     = 4'b1001;
        #1;
        check("wrap_grant3", 32'(bus.req_ready), 32'b1000);
        push_exp(4'hF, 3);
        step();
        check("wrap_grant0", 32'(bus.req_ready), 32'b0001);
        push_exp(4'hF, 0);
        step();
        bus.req_valid = '0;
        step();

        // Asynchronous reset while a result is held under backpressure
        bus.out_ready = 1'b0;
        issue(1, 4'h3, 4'h5, 2'b00, 4'h1);
        bus.req_valid = 4'hF;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy_cnt", 32'(busy_cnt), 32'd0);
        check("arst_req_ready", 32'(bus.req_ready), 32'd0);
        check("arst_out_id", 32'(bus.out_id), 32'd0);
        check("arst_pending", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        exp_busy = '0;
        bus.req_valid = '0;
        #3 rst_n = 1'b1;
        step();
        step();
        check("final_out_valid", 32'(bus.out_valid), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
